// File: rtl/wb_pkg.sv
// Shared Wishbone definitions: cycle-type codes and the bridge state encoding.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACK,
    ST_RBURST,
    ST_ERR
  } bridge_state_t;

endpackage

// File: rtl/wb_spram_bridge.sv
// Wishbone B4 classic slave in front of a registered-read byte-enable SRAM,
// with pipelined incrementing read bursts at one word per clock.
module wb_spram_bridge
  import wb_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_BITS = 8,
  parameter int          DATA_BITS = 32
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [31:0]            wb_adr_i,
  input  logic [DATA_BITS-1:0]   wb_dat_i,
  output logic [DATA_BITS-1:0]   wb_dat_o,
  input  logic [DATA_BITS/8-1:0] wb_sel_i,
  input  logic                   wb_we_i,
  input  logic                   wb_cyc_i,
  input  logic                   wb_stb_i,
  input  logic [2:0]             wb_cti_i,
  output logic                   wb_ack_o,
  output logic                   wb_err_o,
  output logic [ADDR_BITS-1:0]   sram_adr,
  output logic [DATA_BITS-1:0]   sram_dat_o,
  input  logic [DATA_BITS-1:0]   sram_dat_i,
  output logic                   sram_we,
  output logic [DATA_BITS/8-1:0] sram_sel
);

  localparam logic [ADDR_BITS-1:0] ADR_ONE = {{(ADDR_BITS-1){1'b0}}, 1'b1};

  bridge_state_t          r_state, w_state_nxt;
  logic [ADDR_BITS-1:0]   r_burst, w_burst_nxt;
  logic                   w_req, w_hit, w_ack, w_err, w_we;
  logic [ADDR_BITS-1:0]   w_idx;
  logic                   w_unused_adr;

  assign w_req        = wb_cyc_i & wb_stb_i;
  assign w_hit        = (wb_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]);
  assign w_idx        = wb_adr_i[ADDR_BITS+1:2];
  assign w_unused_adr = ^wb_adr_i[1:0];

  assign sram_dat_o = wb_dat_i;
  assign sram_sel   = wb_sel_i;
  assign wb_dat_o   = sram_dat_i;

  // Reset suppresses strobes in the reset cycle itself so an aborted burst gets no further ack.
  assign wb_ack_o = w_ack & ~reset;
  assign wb_err_o = w_err & ~reset;
  assign sram_we  = w_we  & ~reset;

  always_comb begin
    w_state_nxt = r_state;
    w_burst_nxt = r_burst;
    w_ack       = 1'b0;
    w_err       = 1'b0;
    w_we        = 1'b0;
    sram_adr    = w_idx;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (!w_hit) begin
            w_state_nxt = ST_ERR;
          end else if (wb_we_i) begin
            w_we        = 1'b1;
            w_state_nxt = ST_ACK;
          end else if (wb_cti_i == CTI_INCR) begin
            w_burst_nxt = w_idx + ADR_ONE;
            w_state_nxt = ST_RBURST;
          end else begin
            w_state_nxt = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        w_ack       = w_req;
        w_state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        w_err       = w_req;
        w_state_nxt = ST_IDLE;
      end
      ST_RBURST: begin
        // r_burst already points one ahead; a wait state re-reads the word still owed to the master.
        sram_adr = r_burst - ADR_ONE;
        if (!wb_cyc_i) begin
          w_state_nxt = ST_IDLE;
        end else if (wb_stb_i) begin
          if (wb_we_i || !w_hit) begin
            w_state_nxt = ST_IDLE;
          end else begin
            w_ack    = 1'b1;
            sram_adr = r_burst;
            if (wb_cti_i == CTI_INCR) begin
              w_burst_nxt = r_burst + ADR_ONE;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_burst <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_burst <= w_burst_nxt;
    end
  end

endmodule

// File: tb/tb_wb_spram_bridge.sv
// Bench for wb_spram_bridge: directed scenarios plus randomized traffic against a word-array reference.
module tb_wb_spram_bridge;

  localparam logic [31:0] BASE = 32'h3000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i, wb_cyc_i, wb_stb_i;
  logic [2:0]  wb_cti_i;
  logic        wb_ack_o, wb_err_o;
  logic [7:0]  sram_adr;
  logic [31:0] sram_dat_o, sram_dat_i;
  logic        sram_we;
  logic [3:0]  sram_sel;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [256];
  logic [31:0] mem [256];
  logic [31:0] last_rdata;

  always #5 clock = ~clock;

  wb_spram_bridge #(.BASE_ADDR(BASE), .ADDR_BITS(8), .DATA_BITS(32)) dut (
    .clock(clock), .reset(reset),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
    .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .sram_adr(sram_adr), .sram_dat_o(sram_dat_o), .sram_dat_i(sram_dat_i),
    .sram_we(sram_we), .sram_sel(sram_sel)
  );

  // Environment SRAM: 256 x 32, byte-enable write, one-cycle registered read.
  always @(posedge clock) begin
    if (sram_we) begin
      for (int l = 0; l < 4; l++)
        if (sram_sel[l]) mem[sram_adr][8*l +: 8] <= sram_dat_o[8*l +: 8];
    end
    sram_dat_i <= mem[sram_adr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_cti_i = 3'b000; wb_sel_i = 4'h0;
  endtask

  function automatic logic [31:0] word_adr(input int w);
    logic [7:0] b;
    b = w[7:0];
    return BASE | {22'b0, b, 2'b00};
  endfunction

  task automatic ref_write(input logic [7:0] idx, input logic [31:0] dat, input logic [3:0] sel);
    for (int l = 0; l < 4; l++)
      if (sel[l]) ref_mem[idx][8*l +: 8] = dat[8*l +: 8];
  endtask

  task automatic wb_single(input logic [31:0] adr, input logic we,
                           input logic [31:0] dat, input logic [3:0] sel);
    logic       hit;
    logic [7:0] idx;
    hit = (adr[31:10] == BASE[31:10]);
    idx = adr[9:2];
    tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
    wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = 3'b000;
    sample();
    check("req_ack", wb_ack_o, 0);
    check("req_err", wb_err_o, 0);
    check("req_sram_we", sram_we, we & hit);
    if (hit) check("req_sram_adr", sram_adr, idx);
    if (we && hit) begin
      check("req_sram_sel", sram_sel, sel);
      check("req_sram_dat", sram_dat_o, dat);
      ref_write(idx, dat, sel);
    end
    tick();
    sample();
    check("resp_ack", wb_ack_o, hit);
    check("resp_err", wb_err_o, !hit);
    check("resp_sram_we", sram_we, 0);
    if (hit && !we) begin
      check("resp_rdata", wb_dat_o, ref_mem[idx]);
      last_rdata = wb_dat_o;
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      bus_idle();
      sample();
      check("post_ack", wb_ack_o, 0);
      check("post_err", wb_err_o, 0);
    end
  endtask

  // Read burst of n beats; gap_len wait states inserted before beat gap_at (gap_at<0: none).
  task automatic wb_burst(input int start, input int n, input int gap_at, input int gap_len);
    tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_adr_i = word_adr(start);
    wb_cti_i = (n == 1) ? 3'b111 : 3'b010;
    sample();
    check("burst_first_noack", wb_ack_o, 0);
    for (int b = 0; b < n; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          tick();
          wb_stb_i = 1'b0;
          sample();
          check("burst_gap_ack", wb_ack_o, 0);
        end
      end
      tick();
      wb_stb_i = 1'b1;
      wb_adr_i = word_adr(start + b);
      wb_cti_i = (b == n - 1) ? 3'b111 : 3'b010;
      sample();
      check("burst_ack", wb_ack_o, 1);
      check("burst_err", wb_err_o, 0);
      check("burst_data", wb_dat_o, ref_mem[(start + b) % 256]);
    end
    for (int k = 0; k < 2; k++) begin
      tick();
      bus_idle();
      sample();
      check("burst_post_ack", wb_ack_o, 0);
      check("burst_post_err", wb_err_o, 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op, start, n, gap_at;
    reset = 1'b1;
    bus_idle();
    wb_adr_i = '0; wb_dat_i = '0;
    last_rdata = '0;
    repeat (3) tick();
    sample();
    check("rst_ack", wb_ack_o, 0);
    check("rst_err", wb_err_o, 0);
    check("rst_sram_we", sram_we, 0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < 256; i++) begin
      a = $urandom;
      if (i < 4) a = 32'h100 + i;
      wb_single(word_adr(i), 1'b1, a, 4'hF);
    end

    wb_single(32'h3000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF);
    wb_single(32'h3000_0010, 1'b1, 32'h0000_AB00, 4'b0010);
    wb_single(32'h3000_0010, 1'b0, 32'h0, 4'hF);
    check("byte_merge", last_rdata, 32'hDEAD_ABEF);

    wb_burst(0, 4, -1, 0);
    wb_single(word_adr(2), 1'b0, 32'h0, 4'hF);
    check("after_burst_read", last_rdata, 32'h102);

    wb_burst(254, 4, 2, 2);

    wb_single(32'h3000_0400, 1'b0, 32'h0, 4'hF);
    wb_single(32'h3000_0400, 1'b1, 32'h1234_5678, 4'hF);

    // Reset mid-burst.
    tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = word_adr(10); wb_cti_i = 3'b010;
    sample();
    tick();
    sample();
    check("rb_beat0", wb_dat_o, ref_mem[10]);
    tick();
    wb_adr_i = word_adr(11);
    sample();
    check("rb_beat1_ack", wb_ack_o, 1);
    tick();
    reset = 1'b1;
    wb_adr_i = word_adr(12);
    sample();
    check("rb_reset_ack", wb_ack_o, 0);
    check("rb_reset_we", sram_we, 0);
    tick();
    reset = 1'b0;
    bus_idle();
    sample();
    check("rb_after_ack", wb_ack_o, 0);
    wb_single(word_adr(77), 1'b0, 32'h0, 4'hF);

    // Cyc dropped mid-burst.
    tick();
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
    wb_adr_i = word_adr(20); wb_cti_i = 3'b010;
    sample();
    tick();
    sample();
    check("cd_beat0", wb_dat_o, ref_mem[20]);
    tick();
    wb_adr_i = word_adr(21);
    sample();
    check("cd_beat1", wb_dat_o, ref_mem[21]);
    tick();
    wb_cyc_i = 1'b0;
    wb_adr_i = word_adr(22);
    sample();
    check("cd_drop_ack", wb_ack_o, 0);
    tick();
    bus_idle();
    sample();
    check("cd_idle_ack", wb_ack_o, 0);
    wb_single(word_adr(200), 1'b0, 32'h0, 4'hF);

    for (int t = 0; t < 80; t++) begin
      op = $urandom_range(0, 9);
      if (op <= 2) begin
        a = word_adr($urandom_range(0, 255)) | {30'b0, 2'($urandom_range(0, 3))};
        wb_single(a, 1'b1, $urandom, 4'($urandom_range(0, 15)));
      end else if (op <= 4) begin
        a = word_adr($urandom_range(0, 255)) | {30'b0, 2'($urandom_range(0, 3))};
        wb_single(a, 1'b0, 32'h0, 4'hF);
      end else if (op <= 8) begin
        start  = ($urandom_range(0, 1) == 1) ? $urandom_range(248, 255) : $urandom_range(0, 255);
        n      = $urandom_range(1, 6);
        gap_at = (n > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, n - 1) : -1;
        wb_burst(start, n, gap_at, $urandom_range(1, 3));
      end else begin
        a = $urandom;
        if (a[31:10] == BASE[31:10]) a[10] = ~a[10];
        wb_single(a, 1'($urandom_range(0, 1)), $urandom, 4'hF);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_spram_bridge.md
Name: wb_spram_bridge

Overview:
- Wishbone B4 classic slave that fronts a synchronous single-port byte-enable SRAM (spram_32x256 geometry: 256 x 32, registered read).
- Sits between the Caravel-side Wishbone interconnect and the SRAM. It decodes its address window, converts cycles into SRAM strobes and generates ack/err.
- Supports pipelined incrementing read bursts (CTI=010), so a firmware-payload DMA or CPU can stream at one word per clock after the first beat.

Parameters:
- BASE_ADDR, 32'h3000_0000, byte base of the window; must be aligned to the window size.
- ADDR_BITS, 8, SRAM word-address width; window = 4*2^ADDR_BITS bytes.
- DATA_BITS, 32, data width; SEL width = DATA_BITS/8.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- wb_adr_i  in  32  byte address
- wb_dat_i  in  DATA_BITS  write data
- wb_dat_o  out  DATA_BITS  read data, valid only while wb_ack_o is high on a read
- wb_sel_i  in  DATA_BITS/8  byte lanes
- wb_we_i  in  1  write enable
- wb_cyc_i  in  1  cycle valid
- wb_stb_i  in  1  strobe
- wb_cti_i  in  3  cycle type: 000 classic, 010 incrementing, 111 end of burst
- wb_ack_o  out  1  transfer ack
- wb_err_o  out  1  out-of-window error
- sram_adr  out  ADDR_BITS  word address to SRAM
- sram_dat_o  out  DATA_BITS  write data to SRAM
- sram_dat_i  in  DATA_BITS  SRAM read data, valid one cycle after sram_adr
- sram_we  out  1  SRAM write strobe
- sram_sel  out  DATA_BITS/8  SRAM byte enables

Behaviour:
- Reset: state=IDLE. wb_ack_o=0, wb_err_o=0, sram_we=0, burst address register=0. Reset mid-burst aborts with no further ack.
- Request present = wb_cyc_i & wb_stb_i.
- Hit = (wb_adr_i[31:ADDR_BITS+2] == BASE_ADDR[31:ADDR_BITS+2]). Word index = wb_adr_i[ADDR_BITS+1:2]. wb_adr_i[1:0] is ignored.
- sram_dat_o = wb_dat_i. sram_sel = wb_sel_i. wb_dat_o = sram_dat_i, passed through.
- sram_adr is driven from wb_adr_i in IDLE/ACK and from the burst register in RBURST.
- States: IDLE, ACK, RBURST, ERR.
- IDLE, no request: stay.
- IDLE, request & !hit: go to ERR. wb_err_o=1 for exactly one cycle, no SRAM access, then IDLE.
- IDLE, request & hit & write: sram_we=1 in this cycle (combinational), go to ACK. Write lands at this edge; ack next cycle.
- IDLE, request & hit & read & cti!=010: go to ACK. Ack next cycle with data.
- IDLE, request & hit & read & cti==010: go to RBURST. Burst register = index+1 (mod 2^ADDR_BITS).
- ACK: wb_ack_o=1 for one cycle. The request is still visible but is not re-executed. Next state IDLE. Single-transfer throughput is 1 per 2 cycles.
- RBURST: wb_ack_o=1 while request is present. sram_adr = burst register, so the next word arrives one cycle later.
  - Each cycle with ack and cti==010: burst register increments, wrapping 255->0.
  - Ack with cti==111: go to IDLE.
  - wb_stb_i low (wait state): ack=0 and the register holds. Re-present the held address so data stays valid.
  - wb_cyc_i low: go to IDLE immediately, no ack.
  - A write or out-of-window address during a burst: treated as end, go to IDLE with no ack. The master retries classic.
- Write bursts are not pipelined. Each beat runs as a classic write (2 cycles per beat).
- wb_ack_o and wb_err_o are never high together. Neither is asserted without wb_cyc_i & wb_stb_i.
- Read latency is 1 cycle from request to ack. Burst beats 2..N arrive at 1 per cycle.

Decomposition:
- Shared package wb_pkg: CTI constants (CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_EOB=3'b111) and the state enum type for the bridge.
- No sub-module. The SRAM (spram_32x256) is instantiated alongside in the parent, not inside this block.

Test Plan:
- Single write adr=0x3000_0010, dat=0xDEAD_BEEF, sel=1111 -> sram_we high one cycle with sram_adr=4; ack next cycle; ack/err low for 2 cycles after.
- Byte write sel=0010, dat=0x0000_AB00 to word 4, then read word 4 -> wb_dat_o=0xDEAD_ABEF, ack 1 cycle after request.
- Read burst from word 0 of 4 beats (010,010,010,111), words preloaded 0x100+i -> acks in 4 consecutive cycles returning 0x100..0x103; IDLE after.
- Burst starting at word 254, 4 beats -> data for words 254, 255, 0, 1 (wrap); stb dropped for 2 cycles mid-burst -> no ack during the gap and the next beat returns the correct word.
- Access adr=0x3000_0400 (outside the window) -> wb_err_o one cycle, no sram_we, no ack.
- Assert reset in the middle of a burst, then drop cyc mid-burst -> ack=0 the next cycle, state IDLE, and the following single read succeeds.
